// File: rtl/game_phase_sequencer_pkg.sv
// Shared phase encoding and timing defaults for the game flow.
// Imported by the sequencer, its interface and the bench.
package game_timing_pkg;

  localparam int TIME_W = 8;

  localparam int CYC_PER_SEC_D = 50000000;
  localparam int LOGO_SEC_D    = 5;
  localparam int GAME_SEC_D    = 20;
  localparam int SNITCH_HI_D   = 12;
  localparam int SNITCH_LO_D   = 8;
  localparam int SCORE_SEC_D   = 4;

  typedef enum logic [2:0] {
    LOGO       = 3'd0,
    SELECT     = 3'd1,
    GAME       = 3'd2,
    SCORE      = 3'd3,
    PLAY_AGAIN = 3'd4
  } phase_e;

endpackage

// File: rtl/game_phase_sequencer_if.sv
// Player-event inputs and screen-select outputs of the phase sequencer.
// master drives the events, slave is the sequencer.
interface game_phase_if;
  import game_timing_pkg::*;

  logic              selected_a_mode;
  logic              two_player_mode;
  logic              end_game_early;
  logic              end_tutorial;
  logic              restart;

  logic              logo;
  logic              select_mode_screen;
  logic              game_active;
  logic              two_player;
  logic              snitch_powerup;
  logic              end_of_game;
  logic              play_again;
  logic [TIME_W-1:0] time_left;
  logic              sec_tick;

  modport master (
    output selected_a_mode,
    output two_player_mode,
    output end_game_early,
    output end_tutorial,
    output restart,
    input  logo,
    input  select_mode_screen,
    input  game_active,
    input  two_player,
    input  snitch_powerup,
    input  end_of_game,
    input  play_again,
    input  time_left,
    input  sec_tick
  );

  modport slave (
    input  selected_a_mode,
    input  two_player_mode,
    input  end_game_early,
    input  end_tutorial,
    input  restart,
    output logo,
    output select_mode_screen,
    output game_active,
    output two_player,
    output snitch_powerup,
    output end_of_game,
    output play_again,
    output time_left,
    output sec_tick
  );

endinterface

// File: rtl/game_phase_sequencer_sec_tick_gen.sv
// One-second prescaler; clear restarts the second so every phase
// begins with a full second.
module sec_tick_gen #(
  parameter int CYC_PER_SEC = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);

  localparam int CW = $clog2(CYC_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(CYC_PER_SEC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/game_phase_sequencer.sv
// Game flow phase FSM: logo, mode select, timed round, score board,
// play-again; all timing derived from the shared one-second tick.
module game_phase_sequencer
  import game_timing_pkg::*;
#(
  parameter int CYC_PER_SEC = CYC_PER_SEC_D,
  parameter int LOGO_SEC    = LOGO_SEC_D,
  parameter int GAME_SEC    = GAME_SEC_D,
  parameter int SNITCH_HI   = SNITCH_HI_D,
  parameter int SNITCH_LO   = SNITCH_LO_D,
  parameter int SCORE_SEC   = SCORE_SEC_D
) (
  input  logic         clock,
  input  logic         reset,
  game_phase_if.slave  bus
);

  localparam logic [7:0] LOGO_LAST  = 8'(LOGO_SEC - 1);
  localparam logic [7:0] SCORE_LAST = 8'(SCORE_SEC - 1);

  localparam logic [TIME_W-1:0] GAME_T = TIME_W'(GAME_SEC);
  localparam logic [TIME_W-1:0] HI_T   = TIME_W'(SNITCH_HI);
  localparam logic [TIME_W-1:0] LO_T   = TIME_W'(SNITCH_LO);
  localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(1);

  phase_e            state;
  logic [7:0]        sec_cnt;
  logic [TIME_W-1:0] time_left;
  logic              two_player;
  logic              tick;
  logic              leave;

  sec_tick_gen #(
    .CYC_PER_SEC (CYC_PER_SEC)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .clear    (leave),
    .sec_tick (tick)
  );

  // Mirrors the transition conditions below; drives the prescaler clear.
  always_comb begin
    leave = 1'b0;
    unique case (state)
      LOGO:       leave = tick && (sec_cnt == LOGO_LAST);
      SELECT:     leave = bus.selected_a_mode
                        | bus.two_player_mode;
      GAME:       leave = bus.end_tutorial
                        | bus.end_game_early
                        | (tick && (time_left == ONE_T));
      SCORE:      leave = tick && (sec_cnt == SCORE_LAST);
      PLAY_AGAIN: leave = bus.restart;
      default:    leave = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOGO;
      sec_cnt    <= '0;
      time_left  <= '0;
      two_player <= 1'b0;
    end else begin
      unique case (state)
        LOGO: begin
          if (leave) begin
            state   <= SELECT;
            sec_cnt <= '0;
          end else if (tick) begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        SELECT: begin
          if (leave) begin
            state      <= GAME;
            sec_cnt    <= '0;
            time_left  <= GAME_T;
            two_player <= bus.two_player_mode;
          end
        end
        GAME: begin
          if (bus.end_tutorial) begin
            state <= PLAY_AGAIN;
          end else if (bus.end_game_early) begin
            state <= SCORE;
          end else if (tick && (time_left != '0)) begin
            time_left <= time_left - 1'b1;
            if (time_left == ONE_T) state <= SCORE;
          end
        end
        SCORE: begin
          if (leave) begin
            state   <= PLAY_AGAIN;
            sec_cnt <= '0;
          end else if (tick) begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        PLAY_AGAIN: begin
          if (leave) begin
            state      <= SELECT;
            two_player <= 1'b0;
          end
        end
        default: begin
          state   <= LOGO;
          sec_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.logo               = (state == LOGO);
  assign bus.select_mode_screen = (state == SELECT);
  assign bus.game_active        = (state == GAME);
  assign bus.end_of_game        = (state == SCORE);
  assign bus.play_again         = (state == PLAY_AGAIN);
  assign bus.snitch_powerup     = (state == GAME)
                                && (time_left <= HI_T)
                                && (time_left > LO_T);
  assign bus.two_player         = two_player;
  assign bus.time_left          = time_left;
  assign bus.sec_tick           = tick;

endmodule
